// File: rtl/btn_debounce.sv
// btn_debounce: per-channel synchronizer, debouncer and press/release/long-hold event tracker
module btn_debounce #(
  parameter int WIDTH       = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] hold_o,
  output logic             any_press_o
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;
  logic [WIDTH-1:0] s1, s2, commit, rise, fall, fire;
  logic [DW-1:0] db_cnt [WIDTH];
  logic [HW-1:0] hold_cnt [WIDTH];
  state_t st [WIDTH];
  always_comb begin
    commit = '0;
    fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit[i] = (s2[i] != btn_o[i]) && (db_cnt[i] == DB_LAST);
      fire[i] = (st[i] == PRESSED) && !(commit[i] && !s2[i]) && (hold_cnt[i] == HOLD_LAST);
    end
    rise = commit & s2;
    fall = commit & ~s2;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= '0;
      s2 <= '0;
      btn_o <= '0;
      press_o <= '0;
      release_o <= '0;
      hold_o <= '0;
      any_press_o <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
        hold_cnt[i] <= '0;
        st[i] <= RELEASED;
      end
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      btn_o <= btn_o ^ commit;
      press_o <= rise;
      release_o <= fall;
      hold_o <= fire;
      any_press_o <= |rise;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= (s2[i] == btn_o[i] || commit[i]) ? '0 : db_cnt[i] + 1'b1;
        hold_cnt[i] <= rise[i] ? '0 : (st[i] == PRESSED && !fire[i]) ? hold_cnt[i] + 1'b1 : hold_cnt[i];
        st[i] <= fall[i] ? RELEASED : rise[i] ? PRESSED : fire[i] ? HELD : st[i];
      end
    end
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench; stimulus pushes expected events, a monitor pops and compares
module tb_btn_debounce;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] btn, btn_o, press, rel, hold;
  logic any_press;
  int edges = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {int cyc; logic [1:0] p, r, h, b;} ev_t;
  ev_t q[$];

  btn_debounce #(.WIDTH(2), .DB_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .btn_o(btn_o), .press_o(press),
    .release_o(rel), .hold_o(hold), .any_press_o(any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edges);
    end
  endtask

  task automatic push(input int cyc, input logic [1:0] p, r, h, b);
    ev_t e;
    e.cyc = cyc; e.p = p; e.r = r; e.h = h; e.b = b;
    q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (edges < t) @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < edges) begin
        chk("missed_event", 32'(edges), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (press != 0 || rel != 0 || hold != 0 || any_press) begin
        if (q.size() == 0) chk("unexpected_event", {press, rel, hold, any_press}, 0);
        else begin
          ev_t e;
          e = q.pop_front();
          chk("event_cycle", 32'(edges), 32'(e.cyc));
          chk("event_bits", {press, rel, hold, any_press, btn_o}, {e.p, e.r, e.h, |e.p, e.b});
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    btn = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outs", {btn_o, press, rel, hold, any_press}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // clean press on ch0, then quick release before hold
    n = edges;
    btn = 2'b01;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(n + 5);
    chk("t1_btn_before", btn_o, 2'b00);
    wait_until(n + 6);
    chk("t1_btn_after", btn_o, 2'b01);
    btn = 2'b00;
    push(n + 12, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(n + 15);
    drained("t1_drained");
    // bounce 3 high / 1 low for 40 cycles: no events
    for (int k = 0; k < 10; k++) begin
      btn = 2'b01;
      repeat (3) @(negedge clk);
      btn = 2'b00;
      @(negedge clk);
    end
    chk("t2_bounce_btn", btn_o, 2'b00);
    // settle high then long hold
    n = edges;
    btn = 2'b01;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    push(n + 22, 2'b00, 2'b00, 2'b01, 2'b01);
    push(n + 52, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(n + 46);
    chk("t3_btn_held", btn_o, 2'b01);
    btn = 2'b00;
    wait_until(n + 55);
    chk("t3_btn_rel", btn_o, 2'b00);
    drained("t3_drained");
    // short press: release commits 10 edges after press
    n = edges;
    btn = 2'b01;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(n + 10);
    btn = 2'b00;
    push(n + 16, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(n + 20);
    drained("t4a_drained");
    // release commit on the edge hold would fire
    n = edges;
    btn = 2'b01;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(n + 16);
    btn = 2'b00;
    push(n + 22, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(n + 30);
    drained("t4b_drained");
    // async reset while HELD
    n = edges;
    btn = 2'b01;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    push(n + 22, 2'b00, 2'b00, 2'b01, 2'b01);
    wait_until(n + 24);
    chk("t5_pre_btn", btn_o, 2'b01);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_outs", {btn_o, press, rel, hold, any_press}, 0);
    drained("t5_pre_drained");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = edges;
    push(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(n + 6);
    btn = 2'b00;
    push(n + 12, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(n + 15);
    drained("t5_drained");
    // simultaneous press, staggered release
    n = edges;
    btn = 2'b11;
    push(n + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    wait_until(n + 8);
    btn = 2'b10;
    push(n + 14, 2'b00, 2'b01, 2'b00, 2'b10);
    @(negedge clk);
    btn = 2'b00;
    push(n + 15, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_until(n + 25);
    chk("t6_btn_final", btn_o, 2'b00);
    drained("t6_drained");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Input-side counterpart to the LED output path: it conditions raw push-button/switch pins from the board into clean, glitch-free levels and single-cycle events. Per channel it provides:
- 2-flop synchronizer
- counter-based debouncer
- 3-state press tracker emitting press, release and long-hold pulses

It sits between the top-level pins and user logic such as LED mode/counter controls.

Parameters:
WIDTH, 4, number of independent button channels (>=1)
DB_CYCLES, 1000000, consecutive mismatching cycles required to accept a new level (>=1; 10 ms @ 100 MHz)
HOLD_CYCLES, 50000000, cycles a debounced press must persist before hold_o fires (>DB_CYCLES)

Ports:
clk_i  input  1  single clock for all logic
rst_ni  input  1  asynchronous, active-low reset
btn_i  input  WIDTH  raw asynchronous button pins, 1 = pressed
btn_o  output  WIDTH  debounced level per channel
press_o  output  WIDTH  1-cycle pulse when a channel's debounced level goes 0->1
release_o  output  WIDTH  1-cycle pulse when a channel's debounced level goes 1->0
hold_o  output  WIDTH  1-cycle pulse once per press after HOLD_CYCLES held
any_press_o  output  1  OR of press_o, registered alongside it (same cycle)

Behaviour:
- Reset (rst_ni=0, async assert):
  - sync flops, counters, btn_o, press_o, release_o, hold_o, any_press_o all 0; state RELEASED.
  - Deassertion is used directly; the integrator provides deassertion synchronized to clk_i.
- Synchronizer: s1<=btn_i, s2<=s1 every edge. Only s2 feeds logic.
- Debounce counter per channel, width $clog2(DB_CYCLES+1):
  - If s2==btn_o: db_cnt<=0.
  - Else if db_cnt==DB_CYCLES-1: btn_o<=s2, db_cnt<=0 (commit).
  - Else: db_cnt<=db_cnt+1.
  - Any single-cycle return to the stable level restarts the count from 0.
- Latency: raw change present before edge E0 -> btn_o and event pulse visible after edge E(DB_CYCLES+1). With DB_CYCLES=4 that is after E5.
- State machine per channel: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED on 0->1 commit: press_o=1 for that cycle; hold_cnt<=0.
  - PRESSED:
    - hold_cnt increments every edge.
    - At the edge where hold_cnt==HOLD_CYCLES-1: hold_o=1 for one cycle, go HELD. hold_o therefore appears after edge Ep+HOLD_CYCLES, where Ep is the press commit edge.
    - On 1->0 commit: release_o=1, go RELEASED, no hold_o.
    - If release commits on the same edge hold would fire, release wins: no hold_o.
  - HELD -> RELEASED on 1->0 commit: release_o=1. hold_o never repeats within one press.
- Width of hold_cnt: $clog2(HOLD_CYCLES). It stops at its terminal value in HELD (no wrap).
- Outputs are all registered; press_o/release_o/hold_o are never asserted two consecutive cycles on the same channel.
- Channels are fully independent; simultaneous events on multiple channels assert their bits in the same cycle.
- any_press_o is 1 in exactly the cycles where press_o!=0.
- Reset mid-operation:
  - Outputs drop to 0 immediately; no release_o is generated.
  - If btn_i is still 1 after reset deassertion, a fresh press_o occurs DB_CYCLES+2 edges later (first edge after deassert = E0).
- Buttons are defined as released at reset (btn_o=0); there is no initial-state auto-load.

Test Plan:
1. WIDTH=2, DB_CYCLES=4, HOLD_CYCLES=16. btn_i[0] 0->1 before E0, held clean -> btn_o[0]=1 and press_o[0]=any_press_o=1 for exactly one cycle after E5; channel 1 outputs stay 0.
2. Bounce: btn_i[0] toggles 3 cycles high / 1 low repeatedly for 40 cycles -> btn_o, press_o, release_o stay 0. Then hold high -> press_o after 6 edges from the last rising edge.
3. Long hold: press held 40 cycles after press_o -> hold_o[0] pulses once, exactly 16 edges after the press commit edge, never again. Drop btn_i -> release_o[0] pulse and btn_o[0]=0 after E5 of the falling change.
4. Short press: press committed, raw released so that the release commits 10 edges later -> release_o pulse, no hold_o. Release commit coinciding with hold_cnt==15 -> release_o only.
5. Async reset: rst_ni pulled low between edges while in HELD -> all outputs 0 without a clock edge. With btn_i still 1, deassert -> press_o after E5, counting the first edge after deassert as E0.
6. Both channels pressed on the same edge -> press_o=2'b11 and any_press_o=1 in the same single cycle. Staggered releases one cycle apart -> release_o=2'b01 then 2'b10 on consecutive cycles.
